// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file for the RV core. It has two write ports, with ALU writeback
// winning over load writeback, optional write-to-read bypass, and a pending-load scoreboard.

module rv_regfile_rdport #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic            addr_ok,
    input  logic [XLEN-1:0] stored,
    input  logic            stored_busy,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            busy
);
    logic hit_a, hit_b;

    assign hit_a = (BYPASS != 0) && wa_en && (wa_addr == addr);
    assign hit_b = (BYPASS != 0) && wb_en && (wb_addr == addr);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (addr_ok) begin
            data = stored;
            busy = stored_busy;
            if (hit_a)      data = wa_data;
            else if (hit_b) data = wb_data;
            // Load data being forwarded this cycle means the consumer need not stall
            if (hit_b)      busy = 1'b0;
        end
    end
endmodule

module rv_regfile_mp #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_X0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    output logic [NREGS-1:0]    busy_vec,
    output logic                wr_conflict,
    output logic [7:0]          conflict_cnt
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    if ((1 << AW) < NREGS) begin : g_bad_aw
        $error("rv_regfile_mp: AW too small for NREGS");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("rv_regfile_mp: NRD must be 1..4");
    end

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_X0 != 0) && (a == '0));
    endfunction

    function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
        return a[IW-1:0];
    endfunction

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy, busy_nxt;
    logic [NRD-1:0][AW-1:0]     ra;
    logic [NRD-1:0][XLEN-1:0]   rdd;
    logic                       wa_ok, wb_ok, sb_ok, conflict;

    assign wa_ok    = wa_en && addr_ok(wa_addr);
    assign wb_ok    = wb_en && addr_ok(wb_addr);
    assign sb_ok    = sb_set_en && addr_ok(sb_set_addr);
    assign conflict = wa_ok && wb_ok && (wa_addr == wb_addr);

    // Set after clear so a new load issued to the same rd keeps it pending
    always_comb begin
        busy_nxt = busy;
        if (wb_ok) busy_nxt[idx(wb_addr)] = 1'b0;
        if (sb_ok) busy_nxt[idx(sb_set_addr)] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs         <= '0;
            busy         <= '0;
            wr_conflict  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (wb_ok && !conflict) regs[idx(wb_addr)] <= wb_data;
            if (wa_ok)              regs[idx(wa_addr)] <= wa_data;
            busy        <= busy_nxt;
            wr_conflict <= conflict;
            if (conflict && conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

    assign busy_vec = busy;
    assign ra       = rd_addr;
    assign rd_data  = rdd;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic ok;
        assign ok = addr_ok(ra[i]);
        rv_regfile_rdport #(
            .XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)
        ) u_port (
            .addr        (ra[i]),
            .addr_ok     (ok),
            .stored      (ok ? regs[idx(ra[i])] : '0),
            .stored_busy (ok ? busy[idx(ra[i])] : 1'b0),
            .wa_en       (wa_en),
            .wa_addr     (wa_addr),
            .wa_data     (wa_data),
            .wb_en       (wb_en),
            .wb_addr     (wb_addr),
            .wb_data     (wb_data),
            .data        (rdd[i]),
            .busy        (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_rv_regfile_mp.sv
// Bench for rv_regfile_mp: three configurations (bypass, no bypass, 16 regs) share one stimulus
// and are checked against an array-based model of the register file rules.

module tb_rv_regfile_mp;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic        wa_en, wb_en, sb_set_en;
    logic [4:0]  wa_addr, wb_addr, sb_set_addr;
    logic [31:0] wa_data, wb_data;

    logic [63:0] rdd0, rdd1, rdd2;
    logic [1:0]  rdb0, rdb1, rdb2;
    logic [31:0] bv0, bv1;
    logic [15:0] bv2;
    logic        wc0, wc1, wc2;
    logic [7:0]  cc0, cc1, cc2;

    logic [63:0] o_rdd [3];
    logic [1:0]  o_rdb [3];
    logic [31:0] o_bv  [3];
    logic        o_wc  [3];
    logic [7:0]  o_cc  [3];

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    rv_regfile_mp #(.NREGS(32), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd0), .rd_busy(rdb0),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(bv0), .wr_conflict(wc0), .conflict_cnt(cc0));

    rv_regfile_mp #(.NREGS(32), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd1), .rd_busy(rdb1),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(bv1), .wr_conflict(wc1), .conflict_cnt(cc1));

    rv_regfile_mp #(.NREGS(16), .BYPASS(1)) u_n16 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd2), .rd_busy(rdb2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(bv2), .wr_conflict(wc2), .conflict_cnt(cc2));

    always_comb begin
        o_rdd[0] = rdd0; o_rdd[1] = rdd1; o_rdd[2] = rdd2;
        o_rdb[0] = rdb0; o_rdb[1] = rdb1; o_rdb[2] = rdb2;
        o_bv[0]  = bv0;  o_bv[1]  = bv1;  o_bv[2]  = {16'h0, bv2};
        o_wc[0]  = wc0;  o_wc[1]  = wc1;  o_wc[2]  = wc2;
        o_cc[0]  = cc0;  o_cc[1]  = cc1;  o_cc[2]  = cc2;
    end

    // Reference model: one architectural state per configuration
    int          nregs [3] = '{32, 32, 16};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_regs [3][32];
    bit          m_busy [3][32];
    int          m_cnt  [3];
    bit          m_wc   [3];

    function automatic bit mvalid(int k, int a);
        return a != 0 && a < nregs[k];
    endfunction

    function automatic int raddr(int p);
        logic [9:0] ra;
        ra = rd_addr;
        return int'(ra[p*AW +: AW]);
    endfunction

    function automatic logic [31:0] m_rd(int k, int p);
        int a = raddr(p);
        if (!mvalid(k, a)) return 32'h0;
        if (byp[k] && wa_en && int'(wa_addr) == a) return wa_data;
        if (byp[k] && wb_en && int'(wb_addr) == a) return wb_data;
        return m_regs[k][a];
    endfunction

    function automatic bit m_rb(int k, int p);
        int a = raddr(p);
        if (!mvalid(k, a)) return 1'b0;
        if (byp[k] && wb_en && int'(wb_addr) == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [31:0] m_bv(int k);
        logic [31:0] v = '0;
        for (int a = 0; a < nregs[k]; a++) v[a] = m_busy[k][a];
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 32; a++) begin
                m_regs[k][a] = '0;
                m_busy[k][a] = 1'b0;
            end
            m_cnt[k] = 0;
            m_wc[k]  = 1'b0;
        end
    endtask

    task automatic m_update();
        for (int k = 0; k < 3; k++) begin
            bit conf;
            conf = wa_en && wb_en && wa_addr == wb_addr && mvalid(k, int'(wa_addr));
            m_wc[k] = conf;
            if (conf && m_cnt[k] < 255) m_cnt[k]++;
            if (wb_en && mvalid(k, int'(wb_addr))) begin
                m_regs[k][wb_addr] = wb_data;
                m_busy[k][wb_addr] = 1'b0;
            end
            // Port A lands last so it overrides a same-address load writeback
            if (wa_en && mvalid(k, int'(wa_addr))) m_regs[k][wa_addr] = wa_data;
            if (sb_set_en && mvalid(k, int'(sb_set_addr))) m_busy[k][sb_set_addr] = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) m_update();
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; sb_set_en = 0;
        wa_addr = 0; wb_addr = 0; sb_set_addr = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic set_rd(int a0, int a1);
        logic [4:0] x0, x1;
        x0 = 5'(a0); x1 = 5'(a1);
        rd_addr = {x1, x0};
    endtask

    task automatic test_reset();
        rst = 0; idle(); set_rd(5, 31); m_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k] !== 64'h0 || o_rdb[k] !== 2'b0 || o_bv[k] !== 32'h0 ||
                o_wc[k] !== 1'b0 || o_cc[k] !== 8'h0) begin
                failed++;
                $display("FAIL reset_state k=%0d got rd=%h rb=%b bv=%h wc=%b cc=%0d want all 0",
                         k, o_rdd[k], o_rdb[k], o_bv[k], o_wc[k], o_cc[k]);
            end
        end
        rst = 1;
        wa_en = 1; wa_addr = 3; wa_data = 32'h11; sb_set_en = 1; sb_set_addr = 4;
        cyc();
        idle(); set_rd(3, 4);
        rst = 0; m_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k] !== 64'h0 || o_bv[k] !== 32'h0) begin
                failed++;
                $display("FAIL async_reset k=%0d got rd=%h bv=%h want 0", k, o_rdd[k], o_bv[k]);
            end
        end
        wa_en = 1; wa_addr = 3; wa_data = 32'h22;
        cyc();
        wa_data = 32'h33;
        rst = 1;
        cyc();
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k][31:0] !== 32'h33) begin
                failed++;
                $display("FAIL first_write_after_reset k=%0d got %h want 00000033", k, o_rdd[k][31:0]);
            end
        end
        wa_en = 1; wa_addr = 0; wa_data = 32'hDEADBEEF; sb_set_en = 1; sb_set_addr = 0;
        set_rd(0, 0);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k] !== 64'h0 || o_rdb[k] !== 2'b0) begin
                failed++;
                $display("FAIL x0_bypass k=%0d got rd=%h rb=%b want 0", k, o_rdd[k], o_rdb[k]);
            end
        end
        cyc();
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k] !== 64'h0 || o_rdb[k] !== 2'b0 || o_bv[k] !== 32'h0) begin
                failed++;
                $display("FAIL x0_write k=%0d got rd=%h rb=%b bv=%h want 0",
                         k, o_rdd[k], o_rdb[k], o_bv[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want0 [3] = '{32'h12345678, 32'h0, 32'h12345678};
        idle(); set_rd(5, 0);
        wa_en = 1; wa_addr = 5; wa_data = 32'h12345678;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k][31:0] !== want0[k]) begin
                failed++;
                $display("FAIL bypass_same_cycle k=%0d got %h want %h", k, o_rdd[k][31:0], want0[k]);
            end
        end
        cyc();
        idle(); set_rd(0, 5);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k][63:32] !== 32'h12345678) begin
                failed++;
                $display("FAIL read_next_cycle k=%0d got %h want 12345678", k, o_rdd[k][63:32]);
            end
        end
    endtask

    task automatic test_conflict();
        idle();
        wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA;
        wb_en = 1; wb_addr = 7; wb_data = 32'hBBBB;
        cyc();
        idle(); set_rd(7, 7);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_rdd[k] !== 64'h0000AAAA_0000AAAA || o_wc[k] !== 1'b1 || o_cc[k] !== 8'd1) begin
                failed++;
                $display("FAIL conflict k=%0d got rd=%h wc=%b cc=%0d want 0000aaaa wc=1 cc=1",
                         k, o_rdd[k], o_wc[k], o_cc[k]);
            end
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_wc[k] !== 1'b0 || o_cc[k] !== 8'd1) begin
                failed++;
                $display("FAIL conflict_pulse k=%0d got wc=%b cc=%0d want wc=0 cc=1", k, o_wc[k], o_cc[k]);
            end
        end
        for (int n = 0; n < 300; n++) begin
            wa_en = 1; wa_addr = 7; wa_data = $urandom;
            wb_en = 1; wb_addr = 7; wb_data = $urandom;
            cyc();
        end
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_cc[k] !== 8'd255 || o_wc[k] !== 1'b1) begin
                failed++;
                $display("FAIL conflict_saturate k=%0d got cc=%0d wc=%b want 255 1", k, o_cc[k], o_wc[k]);
            end
        end
        cyc();
    endtask

    task automatic test_scoreboard();
        idle(); sb_set_en = 1; sb_set_addr = 9;
        cyc();
        idle(); set_rd(9, 9);
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_bv[k][9] !== 1'b1 || o_rdb[k] !== 2'b11) begin
                failed++;
                $display("FAIL sb_set k=%0d got bv9=%b rb=%b want 1 11", k, o_bv[k][9], o_rdb[k]);
            end
        end
        wb_en = 1; wb_addr = 9; wb_data = 32'h55;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] wd = byp[k] ? 32'h55 : 32'h0;
            logic        wb = byp[k] ? 1'b0 : 1'b1;
            tests_run++;
            if (o_rdd[k][31:0] !== wd || o_rdb[k][0] !== wb) begin
                failed++;
                $display("FAIL load_forward k=%0d got rd=%h rb=%b want %h %b",
                         k, o_rdd[k][31:0], o_rdb[k][0], wd, wb);
            end
        end
        cyc();
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_bv[k][9] !== 1'b0 || o_rdd[k][31:0] !== 32'h55) begin
                failed++;
                $display("FAIL sb_clear k=%0d got bv9=%b rd=%h want 0 55", k, o_bv[k][9], o_rdd[k][31:0]);
            end
        end
        sb_set_en = 1; sb_set_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h66;
        cyc();
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (o_bv[k][9] !== 1'b1 || o_rdd[k][31:0] !== 32'h66) begin
                failed++;
                $display("FAIL sb_set_wins k=%0d got bv9=%b rd=%h want 1 66", k, o_bv[k][9], o_rdd[k][31:0]);
            end
        end
    endtask

    task automatic test_nonpow2();
        idle(); set_rd(20, 20);
        wa_en = 1; wa_addr = 20; wa_data = 32'h1; sb_set_en = 1; sb_set_addr = 20;
        #1;
        tests_run++;
        if (rdd2 !== 64'h0 || rdb2 !== 2'b00 || rdd0[31:0] !== 32'h1) begin
            failed++;
            $display("FAIL oor_bypass got n16=%h rb=%b full=%h want 0 00 1", rdd2, rdb2, rdd0[31:0]);
        end
        cyc();
        idle();
        #1;
        tests_run++;
        if (rdd2 !== 64'h0 || bv2 !== 16'h0200 || bv0[20] !== 1'b1) begin
            failed++;
            $display("FAIL oor_write got n16=%h bv2=%h full_bv20=%b want 0 0200 1", rdd2, bv2, bv0[20]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            wa_en = $urandom_range(0, 1); wb_en = $urandom_range(0, 1);
            sb_set_en = ($urandom_range(0, 2) == 0);
            wa_addr = 5'($urandom_range(0, 1) ? $urandom_range(0, 11) : $urandom_range(0, 31));
            wb_addr = 5'($urandom_range(0, 1) ? $urandom_range(0, 11) : $urandom_range(0, 31));
            sb_set_addr = 5'($urandom_range(0, 1) ? $urandom_range(0, 11) : $urandom_range(0, 31));
            wa_data = $urandom; wb_data = $urandom;
            set_rd($urandom_range(0, 1) ? $urandom_range(0, 11) : $urandom_range(0, 31),
                   $urandom_range(0, 1) ? $urandom_range(0, 11) : $urandom_range(0, 31));
            #1;
            for (int k = 0; k < 3; k++) begin
                logic [63:0] wd = {m_rd(k, 1), m_rd(k, 0)};
                logic [1:0]  wb = {m_rb(k, 1), m_rb(k, 0)};
                tests_run++;
                if (o_rdd[k] !== wd || o_rdb[k] !== wb || o_bv[k] !== m_bv(k) ||
                    o_wc[k] !== m_wc[k] || o_cc[k] !== 8'(m_cnt[k])) begin
                    failed++;
                    $display("FAIL random n=%0d k=%0d got rd=%h rb=%b bv=%h wc=%b cc=%0d want rd=%h rb=%b bv=%h wc=%b cc=%0d",
                             n, k, o_rdd[k], o_rdb[k], o_bv[k], o_wc[k], o_cc[k],
                             wd, wb, m_bv(k), m_wc[k], m_cnt[k]);
                end
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_nonpow2();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
